// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Brief    : Load/store control codes, MEM-stage FSM state encoding and the
//            sub-word store lane-merge helper shared by the memory access unit.
// Revision : 1.0  initial release
// ============================================================================
package mem_pkg;

  // Load codes from decode
  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LBU = 3'b001;
  localparam logic [2:0] LD_LH  = 3'b010;
  localparam logic [2:0] LD_LHU = 3'b011;
  localparam logic [2:0] LD_LW  = 3'b100;

  // Store codes from decode
  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;

  // FSM state encoding
  localparam int         STATE_W  = 3;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD     = 3'd1;
  localparam logic [2:0] S_RMW_RD = 3'd2;
  localparam logic [2:0] S_WR     = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // Insert the low byte/half of data into the addressed lane(s) of word.
  // Any code other than sb/sh replaces the whole word.
  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [31:0] data,
                                             input logic [1:0]  store,
                                             input logic [1:0]  offset);
    logic [31:0] merged;
    merged = word;
    case (store)
      ST_SB: begin
        case (offset)
          2'd0:    merged[7:0]   = data[7:0];
          2'd1:    merged[15:8]  = data[7:0];
          2'd2:    merged[23:16] = data[7:0];
          default: merged[31:24] = data[7:0];
        endcase
      end
      ST_SH: begin
        if (offset[1]) merged[31:16] = data[15:0];
        else           merged[15:0]  = data[15:0];
      end
      default: merged = data;
    endcase
    return merged;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_load_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_load_align
// Brief    : Combinational load extractor: selects the addressed byte/half
//            lane of a little-endian word and sign/zero extends it.
// Revision : 1.0  initial release
// ============================================================================
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  load,
  output logic [31:0] result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection and extension; undefined load codes return the full word
  always_comb begin
    case (offset)
      2'd0:    w_byte = word[7:0];
      2'd1:    w_byte = word[15:8];
      2'd2:    w_byte = word[23:16];
      default: w_byte = word[31:24];
    endcase
    w_half = offset[1] ? word[31:16] : word[15:0];
    case (load)
      LD_LB:   result = {{24{w_byte[7]}}, w_byte};
      LD_LBU:  result = {24'h000000, w_byte};
      LD_LH:   result = {{16{w_half[15]}}, w_half};
      LD_LHU:  result = {16'h0000, w_half};
      default: result = word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : MEM-stage load/store executor on a word-wide req/ack bus.
//            Sub-word stores are done as read-modify-write; the pipeline is
//            stalled until the access completes.
//            Optional macro MEM_ALIGN_CHECK_EN adds misalignment trapping
//            and the align_err output.
// Revision : 1.0  initial release
// ============================================================================
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_rd,
  input  logic              mem_wt,
  input  logic [2:0]        load,
  input  logic [1:0]        store,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       load_data,
  output logic              stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ack
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic              align_err
`endif
);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next_state;
  logic               r_bus_req;
  logic               r_bus_we;
  logic [ADDR_W-1:0]  r_bus_addr;
  logic [31:0]        r_bus_wdata;
  logic [31:0]        r_load_data;
  logic [2:0]         r_load;
  logic [1:0]         r_store;
  logic [1:0]         r_offset;
  logic [31:0]        w_load_ext;
  logic               w_ack;
  logic               w_is_sw;
  logic               w_misaligned;

  // Undefined store codes are treated as full-word stores
  assign w_is_sw = (store != ST_SB) && (store != ST_SH);
  // An ack only counts while a request is actually outstanding
  assign w_ack   = bus_ack & r_bus_req;

`ifdef MEM_ALIGN_CHECK_EN
  logic r_align_err;
  logic w_is_lw;
  assign w_is_lw = (load != LD_LB) && (load != LD_LBU) &&
                   (load != LD_LH) && (load != LD_LHU);
  // Write takes priority, so only the winning access is alignment-checked
  assign w_misaligned = mem_wt ?
      (((store == ST_SH) & addr[0]) | (w_is_sw & (addr[1:0] != 2'b00))) :
      ((((load == LD_LH) | (load == LD_LHU)) & addr[0]) |
       (w_is_lw & (addr[1:0] != 2'b00)));
`else
  assign w_misaligned = 1'b0;
`endif

  mem_load_align u_load_align (
    .word   (bus_rdata),
    .offset (r_offset),
    .load   (r_load),
    .result (w_load_ext)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic; a simultaneous read and write request resolves to the write
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (mem_wt)      w_next_state = w_misaligned ? S_DONE : (w_is_sw ? S_WR : S_RMW_RD);
        else if (mem_rd) w_next_state = w_misaligned ? S_DONE : S_RD;
      end
      S_RD:     if (w_ack) w_next_state = S_DONE;
      S_RMW_RD: if (w_ack) w_next_state = S_WR;
      S_WR:     if (w_ack) w_next_state = S_DONE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Stall holds the pipeline from the request cycle until DONE
  always_comb begin
    stall = ((r_state == S_IDLE) & (mem_rd | mem_wt)) |
            (r_state == S_RD) | (r_state == S_RMW_RD) | (r_state == S_WR);
  end

  // Bus registers, request latching, load capture and store merge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_load_data <= '0;
      r_load      <= LD_LW;
      r_store     <= ST_SW;
      r_offset    <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if ((w_next_state == S_RD) || (w_next_state == S_RMW_RD) || (w_next_state == S_WR)) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= (w_next_state == S_WR);
            r_bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
            r_bus_wdata <= wdata;
            r_load      <= load;
            r_store     <= store;
            r_offset    <= addr[1:0];
          end else if (w_next_state == S_DONE) begin
            r_load_data <= '0;
          end
        end
        S_RD: begin
          if (w_ack) begin
            r_bus_req   <= 1'b0;
            r_load_data <= w_load_ext;
          end
        end
        S_RMW_RD: begin
          // Drop the request for one cycle while the merged word is set up
          if (w_ack) begin
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b1;
            r_bus_wdata <= lane_merge(bus_rdata, r_bus_wdata, r_store, r_offset);
          end
        end
        S_WR: begin
          if (w_ack)           r_bus_req <= 1'b0;
          else if (!r_bus_req) r_bus_req <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  // Remember whether the access was trapped so the flag shows only in DONE
  always_ff @(posedge clk) begin
    if (rst)                  r_align_err <= 1'b0;
    else if (r_state == S_IDLE) r_align_err <= (w_next_state == S_DONE);
  end

  assign align_err = (r_state == S_DONE) & r_align_err;
`endif

  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign load_data = r_load_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Scoreboard bench for mem_access_unit: expected bus transactions
//            and load results are queued at stimulus time and compared when
//            the bus responder acks or the access reaches DONE.
//            Honours MEM_ALIGN_CHECK_EN for the align_err port.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst, mem_rd, mem_wt;
  logic [2:0]  load;
  logic [1:0]  store;
  logic [31:0] addr, wdata;
  logic [31:0] load_data, bus_addr, bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        stall, bus_req, bus_we;
  logic        bus_ack = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
  logic        align_err;
`endif

  typedef struct packed {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
  } bus_txn_t;

  bus_txn_t    q_bus[$];
  logic [31:0] q_load[$];
  logic [31:0] mem [0:63];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          ack_wait = 0;
  int          wait_cnt = 0;
  logic        force_ack = 1'b0;
  logic        exp_align_err = 1'b0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_rd    (mem_rd),
    .mem_wt    (mem_wt),
    .load      (load),
    .store     (store),
    .addr      (addr),
    .wdata     (wdata),
    .load_data (load_data),
    .stall     (stall),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .align_err (align_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Independent reference for load extraction
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                           input logic [2:0] ld);
    logic [31:0] s;
    s = w >> (off * 8);
    case (ld)
      3'd0:    return {{24{s[7]}}, s[7:0]};
      3'd1:    return {24'h0, s[7:0]};
      3'd2:    return {{16{s[15]}}, s[15:0]};
      3'd3:    return {16'h0, s[15:0]};
      default: return w;
    endcase
  endfunction

  // RAM responder: acks after ack_wait idle request cycles, checks each transaction
  always @(posedge clk) begin
    bus_txn_t e;
    #1;
    if (bus_req && !bus_ack) begin
      if (wait_cnt == ack_wait) begin
        check("bus_txn_expected", 32'(q_bus.size() > 0), 32'd1);
        if (q_bus.size() > 0) begin
          e = q_bus.pop_front();
          check("bus_we", 32'(bus_we), 32'(e.we));
          check("bus_addr", bus_addr, e.a);
          if (e.we) check("bus_wdata", bus_wdata, e.d);
        end
        bus_rdata = mem[bus_addr[7:2]];
        bus_ack   = 1'b1;
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
        bus_ack = 1'b0;
      end
    end else begin
      bus_ack  = force_ack;
      wait_cnt = 0;
    end
  end

  // One access: request in IDLE, count stalled cycles, check DONE outputs
  task automatic do_op(input logic rd, input logic wt, input logic [2:0] ld,
                       input logic [1:0] st, input logic [31:0] a, input logic [31:0] d,
                       input int wcyc, input int exp_stall, input string tag);
    int n;
    mem_rd = rd; mem_wt = wt; load = ld; store = st; addr = a; wdata = d;
    ack_wait = wcyc;
    #1;
    check({tag, "_stall_idle"}, 32'(stall), 32'd1);
    @(posedge clk); #1;
    mem_rd = 1'b0; mem_wt = 1'b0;
    n = 1;
    while (stall && n < 60) begin
      n++;
      @(posedge clk); #1;
    end
    check({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall));
    check({tag, "_done_req"}, 32'(bus_req), 32'd0);
    if (rd && !wt) check({tag, "_load_data"}, load_data,
                         (q_load.size() > 0) ? q_load.pop_front() : 32'hxxxxxxxx);
`ifdef MEM_ALIGN_CHECK_EN
    check({tag, "_align_err"}, 32'(align_err), 32'(exp_align_err));
`endif
    @(posedge clk); #1;
`ifdef MEM_ALIGN_CHECK_EN
    check({tag, "_align_err_clr"}, 32'(align_err), 32'd0);
`endif
    check({tag, "_idle_stall"}, 32'(stall), 32'd0);
  endtask

  task automatic do_load(input logic [2:0] ld, input logic [31:0] a, input logic [31:0] word,
                         input int wcyc, input logic [31:0] exp, input string tag);
    mem[a[7:2]] = word;
    q_bus.push_back('{we: 1'b0, a: {a[31:2], 2'b00}, d: 32'h0});
    q_load.push_back(exp);
    do_op(1'b1, 1'b0, ld, 2'b00, a, 32'h0, wcyc, 2 + wcyc, tag);
  endtask

  task automatic do_store(input logic [1:0] st, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] old_word, input logic [31:0] exp_word,
                          input int wcyc, input string tag);
    logic rmw;
    rmw = (st == ST_SB) || (st == ST_SH);
    mem[a[7:2]] = old_word;
    if (rmw) q_bus.push_back('{we: 1'b0, a: {a[31:2], 2'b00}, d: 32'h0});
    q_bus.push_back('{we: 1'b1, a: {a[31:2], 2'b00}, d: exp_word});
    do_op(1'b0, 1'b1, 3'b000, st, a, d, wcyc, rmw ? (4 + 2 * wcyc) : (2 + wcyc), tag);
  endtask

  initial begin
    logic [1:0]  off;
    logic [2:0]  ld;
    logic [31:0] word, a;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    rst = 1'b1; mem_rd = 1'b0; mem_wt = 1'b0; load = 3'b0; store = 2'b0;
    addr = 32'h0; wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_we", 32'(bus_we), 32'd0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    check("rst_load_data", load_data, 32'h0);
    check("rst_stall", 32'(stall), 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
    check("rst_align_err", 32'(align_err), 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // Word load with two wait cycles, then sub-word loads
    do_load(LD_LW,  32'h10, 32'hDEADBEEF, 2, 32'hDEADBEEF, "lw_wait2");
    do_load(LD_LB,  32'h13, 32'h80FF7F01, 0, 32'hFFFFFF80, "lb");
    do_load(LD_LBU, 32'h13, 32'h80FF7F01, 0, 32'h00000080, "lbu");
    do_load(LD_LH,  32'h12, 32'h80FF7F01, 0, 32'hFFFF80FF, "lh");
    do_load(LD_LHU, 32'h12, 32'h80FF7F01, 1, 32'h000080FF, "lhu");
    do_load(LD_LB,  32'h11, 32'h80FF7F01, 0, 32'h0000007F, "lb_pos");
    do_load(3'b111, 32'h38, 32'h13572468, 0, 32'h13572468, "ld_undef");

    // Reset during a read with the ack still pending
    mem[16] = 32'h99999999;
    ack_wait = 3;
    mem_rd = 1'b1; load = LD_LW; addr = 32'h40;
    @(posedge clk); #1;
    mem_rd = 1'b0;
    check("abort_req_before", 32'(bus_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_req", 32'(bus_req), 32'd0);
    check("abort_stall", 32'(stall), 32'd0);
    check("abort_load_data", load_data, 32'h0);
    @(posedge clk); #2;
    force_ack = 1'b1;
    @(posedge clk); #2;
    force_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("stray_ack_req", 32'(bus_req), 32'd0);
    check("stray_ack_stall", 32'(stall), 32'd0);
    check("stray_ack_load_data", load_data, 32'h0);

    // Stores: read-modify-write and full word
    do_store(ST_SB, 32'h21, 32'h000000AB, 32'h11223344, 32'h1122AB44, 0, "sb");
    do_store(ST_SB, 32'h20, 32'h00000011, 32'hAABBCCDD, 32'hAABBCC11, 1, "sb_wait1");
    do_store(ST_SH, 32'h22, 32'h0000CAFE, 32'h00000000, 32'hCAFE0000, 0, "sh");
    do_store(ST_SH, 32'h24, 32'hFFFF9999, 32'h12345678, 32'h12349999, 2, "sh_lo_wait2");
    do_store(ST_SW, 32'h30, 32'h55AA1234, 32'h00000000, 32'h55AA1234, 0, "sw");
    do_store(2'b11, 32'h34, 32'h0BADF00D, 32'h00000000, 32'h0BADF00D, 0, "st_undef");

    // Read and write requested together: the write wins
    mem[13] = 32'h01020304;
    q_bus.push_back('{we: 1'b1, a: 32'h34, d: 32'h76543210});
    do_op(1'b1, 1'b1, LD_LW, ST_SW, 32'h34, 32'h76543210, 0, 2, "rd_wt_both");

    // Randomised aligned loads
    for (int i = 0; i < 8; i++) begin
      ld  = 3'($urandom_range(0, 4));
      off = 2'($urandom_range(0, 3));
      if (ld == LD_LH || ld == LD_LHU) off[0] = 1'b0;
      if (ld == LD_LW) off = 2'b00;
      word = $urandom;
      a = 32'h80 + 32'(i * 4) + 32'(off);
      do_load(ld, a, word, i % 3, ref_load(word, off, ld), "rand_load");
    end

    // Misaligned word load
    mem[0] = 32'h0F0E0D0C;
`ifdef MEM_ALIGN_CHECK_EN
    q_load.push_back(32'h0);
    exp_align_err = 1'b1;
    do_op(1'b1, 1'b0, LD_LW, 2'b00, 32'h2, 32'h0, 0, 1, "lw_misalign");
    exp_align_err = 1'b0;
`else
    do_load(LD_LW, 32'h2, 32'h0F0E0D0C, 0, 32'h0F0E0D0C, "lw_misalign");
`endif

    repeat (2) @(posedge clk);
    #1;
    check("bus_queue_drained", 32'(q_bus.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
